// File: rtl/fpu_md_pkg.sv
// Shared types and default latencies for the two-requester mul/div scheduler.
package fpu_md_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 26;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; combinational grant, pointer advances only on upd_en.
module rr_arb2 (
  input  logic       clk,
  input  logic       arst,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt
);

  // ptr_q = 0 favours requester 0, 1 favours requester 1
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    if (upd_en && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fpu_md_sched.sv
// Schedules two requesters onto one shared mul/div datapath, one operation in flight.
// Response appears LAT+1 cycles after accept and is held until rsp_ready.
module fpu_md_sched
  import fpu_md_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_op,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  output logic            dp_start,
  output logic            dp_en,
  output logic            dp_op,
  output logic [31:0]     dp_a,
  output logic [31:0]     dp_b,
  input  logic [31:0]     dp_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [31:0]     rsp_data
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_e             op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic            id_q, id_d;
  logic            start_q, start_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;

  logic [1:0]      gnt;
  logic            accept;
  logic            acc_id;

  assign accept = (state_q == ST_IDLE) && !arst && (gnt != 2'b00);
  assign acc_id = gnt[1];

  rr_arb2 u_arb (
    .clk    (clk),
    .arst   (arst),
    .req    (req_valid),
    .upd_en (accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_e'(req_op[acc_id]);
          a_d     = req_a[acc_id];
          b_d     = req_b[acc_id];
          id_d    = acc_id;
          cnt_d   = req_op[acc_id] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
          start_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        // First RESP cycle is the one where the datapath result is valid; capture it.
        if (!rsp_valid_q) begin
          rsp_data_d  = dp_result;
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = ((state_q == ST_IDLE) && !arst) ? gnt : 2'b00;
  assign dp_start  = start_q;
  assign dp_en     = (state_q == ST_RUN);
  assign dp_op     = op_q;
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fpu_md_sched.sv
// Bench for fpu_md_sched: vector table plus directed backpressure, abort and arbitration sequences.
module tb_fpu_md_sched;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 26;

  logic             clk = 1'b0;
  logic             arst;
  logic [1:0]       req_valid, req_ready, req_op;
  logic [1:0][31:0] req_a, req_b;
  logic             dp_start, dp_en, dp_op;
  logic [31:0]      dp_a, dp_b, dp_result;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [31:0]      rsp_data;

  fpu_md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .dp_start(dp_start), .dp_en(dp_en), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        id;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          acc;
    int          lat;
  } sb_t;

  vec_t  vt[6];
  sb_t   q[$];
  logic  gnt_log[$];
  int    nvec = 0, nerr = 0;
  int    cyc = 0, n_done = 0, rsp_rises = 0;
  int    age = 0, en_cnt = 0, exp_len = 0;
  logic  prev_start = 1'b0, prev_en = 1'b0, prev_rv = 1'b0, prev_hs = 1'b0, prev_id = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference results for the operand pairs used by the bench.
  function automatic logic [31:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 6; i++)
      if (vt[i].op == op && vt[i].a == a && vt[i].b == b) return vt[i].exp;
    return 32'hBAD00000 ^ a ^ b;
  endfunction

  // Datapath model, monitor and scoreboard.
  always @(negedge clk) begin
    if (arst) begin
      q.delete();
      age = 0;
      dp_result = 32'hDEADBEEF;
      prev_start = 1'b0; prev_en = 1'b0; prev_rv = 1'b0; prev_hs = 1'b0;
    end else begin
      if (dp_start) age = 1;
      else if (age != 0) age = age + 1;
      dp_result = (age == (dp_op ? DIV_LAT : MUL_LAT) + 1) ? model(dp_op, dp_a, dp_b) : 32'hDEADBEEF;

      chk("rdy_not_both", 32'(&req_ready), 32'd0);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_t e;
          e.id  = 1'(i);
          e.op  = req_op[i];
          e.a   = req_a[i];
          e.b   = req_b[i];
          e.exp = model(req_op[i], req_a[i], req_b[i]);
          e.acc = cyc + 1;
          e.lat = req_op[i] ? DIV_LAT : MUL_LAT;
          q.push_back(e);
          gnt_log.push_back(1'(i));
        end
      end

      if (dp_start) begin
        chk("dp_start_pulse", 32'(prev_start), 32'd0);
        if (q.size() == 0) chk("dp_start_no_accept", q.size(), 1);
        else begin
          chk("dp_op", 32'(dp_op), 32'(q[$].op));
          chk("dp_a", dp_a, q[$].a);
          chk("dp_b", dp_b, q[$].b);
          chk("dp_en_at_start", 32'(dp_en), 32'd1);
          exp_len = q[$].lat;
        end
        en_cnt = 0;
      end
      if (dp_en) begin
        en_cnt++;
        if (q.size() != 0) begin
          chk("dp_a_stable", dp_a, q[$].a);
          chk("dp_b_stable", dp_b, q[$].b);
        end
      end
      if (prev_en && !dp_en) chk("dp_en_len", en_cnt, exp_len);

      if (rsp_valid && !prev_rv) begin
        rsp_rises++;
        if (q.size() == 0) chk("rsp_unexpected", q.size(), 1);
        else chk("rsp_latency", cyc - q[0].acc, q[0].lat + 1);
      end
      if (prev_rv && !prev_hs) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_hold_id", 32'(rsp_id), 32'(prev_id));
        chk("rsp_hold_data", rsp_data, prev_data);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() != 0) begin
          chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
          chk("rsp_data", rsp_data, q[0].exp);
          void'(q.pop_front());
        end
        n_done++;
      end

      prev_start = dp_start;
      prev_en    = dp_en;
      prev_rv    = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      prev_id    = rsp_id;
      prev_data  = rsp_data;
    end
  end

  task automatic wait_done(input int target);
    for (int k = 0; k < 400 && n_done < target; k++) @(negedge clk);
    chk("rsp_done", n_done, target);
  endtask

  task automatic wait_accept(input int id);
    for (int k = 0; k < 200 && !req_ready[id]; k++) @(negedge clk);
    chk("accept", 32'(req_ready[id]), 32'd1);
  endtask

  task automatic do_req(input int idx);
    vec_t e;
    int   done0;
    e = vt[idx];
    done0 = n_done;
    @(posedge clk); #1;
    req_valid[e.id] = 1'b1;
    req_op[e.id]    = e.op;
    req_a[e.id]     = e.a;
    req_b[e.id]     = e.b;
    @(negedge clk);
    wait_accept(int'(e.id));
    @(posedge clk); #1;
    req_valid[e.id] = 1'b0;
    req_a[e.id]     = 32'h12345678;
    req_b[e.id]     = ~e.b;
    wait_done(done0 + 1);
  endtask

  initial begin
    int base, done0, rises0, k;
    vt[0] = '{1'b0, 1'b0, 32'h40400000, 32'h40000000, 32'h40C00000}; // 3*2
    vt[1] = '{1'b1, 1'b1, 32'h41200000, 32'h40000000, 32'h40A00000}; // 10/2
    vt[2] = '{1'b1, 1'b0, 32'h40200000, 32'hC0000000, 32'hC0A00000}; // 2.5*-2
    vt[3] = '{1'b0, 1'b1, 32'h3F800000, 32'h40800000, 32'h3E800000}; // 1/4
    vt[4] = '{1'b0, 1'b0, 32'h40E00000, 32'h41000000, 32'h42600000}; // 7*8
    vt[5] = '{1'b1, 1'b1, 32'h41100000, 32'h40400000, 32'h40400000}; // 9/3

    arst = 1'b1; req_valid = 2'b11; req_op = 2'b00; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; dp_result = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_dp_start", 32'(dp_start), 32'd0);
    chk("rst_dp_en", 32'(dp_en), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    arst = 1'b0; req_valid = 2'b00;

    for (int i = 0; i < 6; i++) do_req(i);

    // Response backpressure with requester 1 waiting.
    done0 = n_done;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_op[0] = vt[0].op; req_a[0] = vt[0].a; req_b[0] = vt[0].b;
    @(negedge clk);
    wait_accept(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_op[1] = vt[4].op; req_a[1] = vt[4].a; req_b[1] = vt[4].b;
    for (k = 0; k < 100 && !rsp_valid; k++) @(negedge clk);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(rsp_id), 32'd0);
      chk("bp_hold_data", rsp_data, vt[0].exp);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_grant_next", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_done(done0 + 2);

    // Reset in the third RUN cycle of a divide.
    rises0 = rsp_rises;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_op[1] = vt[1].op; req_a[1] = vt[1].a; req_b[1] = vt[1].b;
    @(negedge clk);
    wait_accept(1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_dp_start", 32'(dp_start), 32'd0);
    chk("abort_dp_en", 32'(dp_en), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    chk("abort_rsp_id", 32'(rsp_id), 32'd0);
    chk("abort_rsp_data", rsp_data, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_rsp", rsp_rises, rises0);
    do_req(2);

    // Both requesters held valid: round-robin alternation.
    base  = gnt_log.size();
    done0 = n_done;
    @(posedge clk); #1;
    req_op = 2'b00;
    req_a[0] = vt[0].a; req_b[0] = vt[0].b;
    req_a[1] = vt[4].a; req_b[1] = vt[4].b;
    req_valid = 2'b11;
    for (k = 0; k < 400 && gnt_log.size() < base + 4; k++) begin
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    wait_done(done0 + 4);
    chk("arb_count", gnt_log.size(), base + 4);
    for (int i = 0; i < 4; i++) begin
      if (gnt_log.size() > base + i) chk("arb_order", 32'(gnt_log[base + i]), 32'(i % 2));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
